// File: rtl/memory_tank_sched.sv
// rtl/memory_tank_sched.sv - slot scheduler gating one mercury-tank word (short or long) per request
module memory_tank_sched #(
   parameter int DIGITS = 18,
   parameter int WORDS  = 32,
   parameter int AW     = 5
) (
   input  logic          r2_clk,
   input  logic          r2_rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    req_op,
   input  logic [AW-1:0] req_addr,
   input  logic          req_long,
   output logic          done,
   output logic          t3_in,
   output logic          t3_out,
   output logic          t3_clr,
   output logic [4:0]    digit,
   output logic [AW-1:0] slot,
   output logic          rev
);

   localparam logic [4:0]    DIG_LAST  = 5'(DIGITS - 1);
   localparam logic [AW-1:0] SLOT_LAST = AW'(WORDS - 1);
   localparam int            LW        = $clog2(2 * DIGITS);
   localparam logic [LW-1:0] LEN_SHORT = LW'(DIGITS - 1);
   localparam logic [LW-1:0] LEN_LONG  = LW'(2 * DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [1:0]    op_q;
   logic          long_q;
   logic [AW-1:0] tgt_q;
   logic [LW-1:0] len_cnt;
   logic          digit_wrap;
   logic          slot_hit;
   logic          xfer_last;
   logic          is_write;
   logic          is_clear;
   logic          is_read;

   assign digit_wrap = (digit == DIG_LAST);
   assign rev        = (digit == 5'd0) && (slot == '0);

   // Free-running position of the circulating tank; never stalled by requests.
   always_ff @(posedge r2_clk or posedge r2_rst) begin
      if (r2_rst) begin
         digit <= 5'd0;
         slot  <= '0;
      end else if (digit_wrap) begin
         digit <= 5'd0;
         slot  <= (slot == SLOT_LAST) ? '0 : slot + AW'(1);
      end else begin
         digit <= digit + 5'd1;
      end
   end

   // Last digit of the slot preceding the target, so the registered gates open on its first digit.
   assign slot_hit  = digit_wrap && (slot == tgt_q - AW'(1));
   assign xfer_last = (len_cnt == (long_q ? LEN_LONG : LEN_SHORT));

   assign is_write = (op_q == 2'b01);
   assign is_clear = (op_q == 2'b10);
   assign is_read  = !(is_write || is_clear);

   always_ff @(posedge r2_clk or posedge r2_rst) begin
      if (r2_rst) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid && req_ready) state_nxt = S_WAIT;
         S_WAIT:  if (slot_hit)               state_nxt = S_XFER;
         S_XFER:  if (xfer_last)              state_nxt = S_DONE;
         S_DONE:                              state_nxt = S_IDLE;
         default:                             state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE);
      done      = (state == S_DONE);
   end

   always_ff @(posedge r2_clk or posedge r2_rst) begin
      if (r2_rst) begin
         op_q    <= 2'b00;
         long_q  <= 1'b0;
         tgt_q   <= '0;
         len_cnt <= '0;
         t3_in   <= 1'b0;
         t3_out  <= 1'b0;
         t3_clr  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  op_q   <= req_op;
                  long_q <= req_long;
                  tgt_q  <= req_long ? {req_addr[AW-1:1], 1'b0} : req_addr;
               end
            end
            S_WAIT: begin
               if (slot_hit) begin
                  len_cnt <= '0;
                  t3_out  <= is_read;
                  t3_in   <= is_write;
                  t3_clr  <= is_write || is_clear;
               end
            end
            S_XFER: begin
               if (xfer_last) begin
                  t3_in  <= 1'b0;
                  t3_out <= 1'b0;
                  t3_clr <= 1'b0;
               end else begin
                  len_cnt <= len_cnt + LW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_tank_sched.sv
// tb/tb_memory_tank_sched.sv - random and directed checks of memory_tank_sched against a revolution-time model
module tb_memory_tank_sched;

   localparam int DIGITS = 18;
   localparam int WORDS  = 32;
   localparam int AW     = 5;
   localparam int REV    = DIGITS * WORDS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [1:0]    req_op = 2'b00;
   logic [AW-1:0] req_addr = '0;
   logic          req_long = 1'b0;
   logic          req_ready, done, t3_in, t3_out, t3_clr, rev;
   logic [4:0]    digit;
   logic [AW-1:0] slot;

   memory_tank_sched #(.DIGITS(DIGITS), .WORDS(WORDS), .AW(AW)) dut (
      .r2_clk(clk), .r2_rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_long(req_long), .done(done),
      .t3_in(t3_in), .t3_out(t3_out), .t3_clr(t3_clr), .digit(digit), .slot(slot), .rev(rev)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // Model: absolute cycle t since reset release; one outstanding request described by its gate window.
   int t = 0;
   bit mdl_on = 0;
   bit have_req = 0;
   int ts = 0, te = 0, m_op = 0;
   int accepts = 0, last_ta = 0;
   int rise_t = -1, fall_t = -1, done_t = -1, windows = 0;
   bit prev_g = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [15:0] e, a;
      bit rdy, g, dn, wr, cl, gates;
      int tgt, base;
      if (mdl_on) begin
         rdy = !have_req;
         g   = have_req && t >= ts && t <= te;
         dn  = have_req && t == te + 1;
         wr  = (m_op == 1);
         cl  = (m_op == 2);
         e = {rdy, dn, g && wr, g && !(wr || cl), g && (wr || cl),
              5'(t % DIGITS), 5'((t / DIGITS) % WORDS), (t % REV) == 0};
         a = {req_ready, done, t3_in, t3_out, t3_clr, digit, slot, rev};
         compared++;
         if (a !== e) begin
            mismatched++;
            $display("FAIL cycle t=%0d {ready,done,in,out,clr,digit,slot,rev}: got %h expected %h", t, a, e);
         end
         gates = t3_in || t3_out || t3_clr;
         if (gates && !prev_g) begin rise_t = t; windows++; end
         if (!gates && prev_g) fall_t = t;
         if (done) done_t = t;
         prev_g = gates;
         if (dn) have_req = 0;
         if (rdy && req_valid) begin
            tgt  = req_long ? (int'(req_addr) & ~1) : int'(req_addr);
            base = t + 2;
            ts   = base + ((tgt * DIGITS - (base % REV) + REV) % REV);
            te   = ts + (req_long ? 2 : 1) * DIGITS - 1;
            m_op = int'(req_op);
            have_req = 1;
            accepts++;
            last_ta = t;
         end
         t++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_phase(int d, int s);
      int n = 0;
      while (!((t % DIGITS) == d && ((t / DIGITS) % WORDS) == s) && n < REV + 5) begin
         step();
         n++;
      end
      check("wait_phase_timeout", n < REV + 5, 1);
   endtask

   task automatic issue(int op, int addr, bit lng);
      req_valid = 1'b1;
      req_op    = 2'(op);
      req_addr  = AW'(addr);
      req_long  = lng;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (have_req && n < 1400) begin
         step();
         n++;
      end
      check("wait_idle_timeout", have_req, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired at t=%0d", t);
      $fatal(1, "watchdog");
   end

   initial begin
      int ta, w0, n;
      #2;
      check("reset_rev", rev, 1);
      check("reset_digit", digit, 0);
      check("reset_slot", slot, 0);
      check("reset_ready", req_ready, 1);
      check("reset_gates", {t3_in, t3_out, t3_clr}, 0);
      check("reset_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0; t = 0; mdl_on = 1;

      // Short read of slot 5 from the top of the revolution.
      wait_phase(0, 0);
      ta = t;
      issue(0, 5, 0);
      wait_idle();
      check("short_rise_lat", rise_t - ta, 90);
      check("short_len", fall_t - rise_t, 18);
      check("short_done_lag", done_t - (fall_t - 1), 1);

      // Long write at odd address snaps to slot 6.
      issue(1, 7, 1);
      wait_idle();
      check("long7_slot", (rise_t / DIGITS) % WORDS, 6);
      check("long7_digit", rise_t % DIGITS, 0);
      check("long7_len", fall_t - rise_t, 36);

      // Clear of slot 0 accepted near the end of slot 31.
      wait_phase(5, 31);
      ta = t;
      issue(2, 0, 0);
      wait_idle();
      check("wrap_clr_lat", rise_t - ta, 13);
      check("wrap_clr_len", fall_t - rise_t, 18);

      // Long write at the top of the tank ends exactly at the rollover.
      issue(1, 30, 1);
      wait_idle();
      check("long30_slot", (rise_t / DIGITS) % WORDS, 30);
      check("long30_fall", fall_t % REV, 0);

      // Accept in the very cycle the wait condition holds misses the slot.
      wait_phase(17, 2);
      ta = t;
      issue(0, 3, 0);
      wait_idle();
      check("missed_lat", rise_t - ta, 577);

      // Busy ignore: valid held high throughout, second request waits for IDLE.
      w0 = windows;
      req_valid = 1'b1; req_op = 2'b00; req_addr = AW'(4); req_long = 1'b0;
      step();
      req_addr = AW'(9);
      n = 0;
      while (accepts < 7 && n < 1400) begin step(); n++; end
      req_valid = 1'b0;
      check("busy_accepts", accepts, 7);
      check("busy_next_accept", last_ta - done_t, 1);
      wait_idle();
      check("busy_windows", windows - w0, 2);
      check("busy_second_slot", (rise_t / DIGITS) % WORDS, 9);

      // Randomised requests, including the reserved opcode.
      for (int i = 0; i < 12; i++) begin
         n = $urandom_range(0, 30);
         repeat (n) step();
         issue($urandom_range(0, 3), $urandom_range(0, WORDS - 1), 1'($urandom_range(0, 1)));
         wait_idle();
      end

      // Reset in the middle of a write window.
      issue(1, 12, 0);
      n = 0;
      while (t != ts + 5 && n < 1400) begin step(); n++; end
      check("xfer_reach", t, ts + 5);
      mdl_on = 0;
      #3;
      rst = 1'b1;
      #1;
      check("rst_async_in", t3_in, 0);
      check("rst_async_clr", t3_clr, 0);
      check("rst_async_done", done, 0);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_done", done, 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; t = 0; have_req = 0; prev_g = 0; mdl_on = 1;
      @(negedge clk); #1;
      check("post_rst_digit", digit, 0);
      check("post_rst_slot", slot, 0);
      check("post_rst_rev", rev, 1);
      @(posedge clk); #1;
      ta = t;
      issue(2, 1, 0);
      wait_idle();
      check("post_rst_clr_lat", rise_t - ta, 17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/memory_tank_sched.md
# memory_tank_sched

Slot scheduler for one EDSAC mercury-tank memory unit: 32 short words, i.e. 16 long words, circulating as 18-digit minor cycles.
- Tracks the circulating position of the tank with free-running digit and minor-cycle counters.
- Accepts one read, write or clear request at a time.
- Drives the tank's `in`/`out`/`clr` gate strobes for exactly the addressed word's minor cycle(s).
- Sits between the store-access sequencer and a tank instance such as `memory_r2_up_3`; its three gate outputs connect directly to that tank's `r2_up_t3_in`, `r2_up_t3_out` and `r2_up_t3_clr`.

## Interface
Parameters:
- DIGITS, 18: digit periods per minor cycle (short word slot).
- WORDS, 32: short-word slots per tank revolution; power of two.
- AW, 5: address width, log2(WORDS).

Ports (one clock; reset is asynchronous and active-high):
- r2_clk  in  1  digit clock; all state on rising edge.
- r2_rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  00 read, 01 write, 10 clear, 11 reserved (treated as read).
- req_addr  in  AW  short-word address within tank.
- req_long  in  1  long-word access; addr[0] forced to 0.
- done  out  1  one-cycle pulse when the transfer completes.
- t3_in  out  1  tank input gate (write).
- t3_out  out  1  tank output gate (read).
- t3_clr  out  1  tank recirculation clear (write, clear).
- digit  out  5  current digit counter, 0..DIGITS-1.
- slot  out  AW  current minor-cycle counter, 0..WORDS-1.
- rev  out  1  high when digit==0 and slot==0.

## Operation
- **Counters**
  - `digit` increments every cycle and wraps DIGITS-1 → 0.
  - `slot` increments when `digit` wraps and rolls over WORDS-1 → 0.
  - Both counters run in every state; a request never stalls them.
- **FSM states:** IDLE, WAIT, XFER, DONE.
- **IDLE**
  - `req_ready`=1.
  - On req_valid&&req_ready, latch op, long and tgt. tgt = req_long ? {addr[AW-1:1],0} : addr.
  - Go to WAIT.
- **WAIT**
  - When digit==DIGITS-1 and slot==(tgt-1) mod WORDS, go to XFER.
  - In the same edge, set the registered gates:
    - read: t3_out=1.
    - write: t3_in=1, t3_clr=1.
    - clear: t3_clr=1.
- **XFER**
  - Gates hold for DIGITS cycles (short) or 2·DIGITS cycles (long), counted by an internal length counter.
  - On the last digit of the final slot, clear all gates and go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **Reserved op:** req_op=11 executes as a read.
- **Read behaviour:** read is non-destructive; recirculation continues, and t3_clr is never asserted on a read.

## Timing
- **Reset values:**
  - state IDLE, digit=0, slot=0.
  - t3_in=t3_out=t3_clr=0, done=0.
  - req_ready=1, rev=1.
- **Gate alignment:** gates are registered. The first high cycle is the cycle with digit==0 and slot==tgt, and the last high cycle is digit==DIGITS-1 of slot tgt (short) or tgt+1 (long).
- **Latency:**
  - Gates rise at the first slot-tgt start that is at least 2 cycles after the accept edge.
  - Maximum accept-to-gate latency: WORDS·DIGITS+1 cycles.
  - done is high 1 cycle after gates fall.
- **Missed slot:** an accept in the same cycle the WAIT condition would hold misses that slot and waits a full revolution (576 cycles).
- **Long word at the top of the tank:** tgt=WORDS-2 occupies slots 30 and 31. The gates drop before slot 0; a long access never spans the rollover.
- **Back-to-back requests:** the next request can be accepted in the cycle after done (IDLE). req_valid during WAIT/XFER/DONE is ignored, with no latching.
- **Reset mid-operation:** asserting r2_rst clears the gates immediately (asynchronously), aborts the transfer without a done pulse, and resets the counters.

## Test plan
- **Reset:** assert r2_rst during XFER of a write → t3_in/t3_clr fall without waiting for a clock; done stays 0; after release digit=0, slot=0, rev=1.
- **Short read:** read addr=5 accepted at digit=0, slot=0 → t3_out high for exactly 18 cycles, starting at slot=5, digit=0; t3_clr=0 throughout; done 1 cycle after t3_out falls.
- **Long write, odd address:** long write addr=7 → treated as tgt=6; t3_in and t3_clr high for 36 cycles covering slots 6–7.
- **Wrap targets:**
  - Short clear addr=0 accepted at slot=31, digit=5 → t3_clr rises at slot=0, digit=0, 13 cycles later.
  - Long write addr=30 → gates cover slots 30–31 and fall before slot 0.
- **Missed slot:** read addr=3 accepted at slot=2, digit=17 → gates rise at slot=3, digit=0 of the next revolution (577 cycles after accept).
- **Busy ignore:** req_valid held high with new addr=9 throughout an addr=4 read → req_ready=0 until IDLE; the addr=9 request is accepted the cycle after done, and exactly one gate window occurs per accepted request.
